// File: rtl/hazard_match_tracker_if.sv
// Decode-side metadata, hazard-unit controls and match/flag results between the tracker and the hazard unit.
// The tracker takes the slave modport; the hazard unit or its stand-in takes the master modport.
interface hazard_match_tracker_if #(
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
);
  logic              ValidD;
  logic [ADDR_W-1:0] RA1D;
  logic [ADDR_W-1:0] RA2D;
  logic [ADDR_W-1:0] WA3D;
  logic              RegWriteD;
  logic              MemToRegD;
  logic              StallD;
  logic              FlushE;

  logic              Match_1E_M;
  logic              Match_1E_W;
  logic              Match_2E_M;
  logic              Match_2E_W;
  logic              Match_12D_E;
  logic              RegWriteM;
  logic              RegWriteW;
  logic              MemToRegE;
  logic [CNT_W-1:0]  StallCount;
  logic [CNT_W-1:0]  BubbleCount;

  modport master (
    output ValidD, RA1D, RA2D, WA3D, RegWriteD, MemToRegD, StallD, FlushE,
    input  Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E,
    input  RegWriteM, RegWriteW, MemToRegE, StallCount, BubbleCount
  );

  modport slave (
    input  ValidD, RA1D, RA2D, WA3D, RegWriteD, MemToRegD, StallD, FlushE,
    output Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E,
    output RegWriteM, RegWriteW, MemToRegE, StallCount, BubbleCount
  );
endinterface

// File: rtl/hazard_match_tracker.sv
// Carries register metadata through the E/M/W stages and produces the match terms and stage flags used for hazard detection.
// Latency: match outputs and flags are combinational from the stage registers; the stage registers advance every clock.
// Backpressure: none; StallD only counts, because the datapath holds D; FlushE loads a bubble into E.
module hazard_match_tracker #(
  parameter int ADDR_W = 4,
  parameter int PC_REG = 15,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hazard_match_tracker_if.slave hz
);
  localparam logic [ADDR_W-1:0] PC_IDX  = ADDR_W'(PC_REG);
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

  logic              ValidE, RegWriteE, MemToRegE_r;
  logic [ADDR_W-1:0] RA1E, RA2E, WA3E;
  logic              ValidM, RegWriteM_r;
  logic [ADDR_W-1:0] WA3M;
  logic              ValidW, RegWriteW_r;
  logic [ADDR_W-1:0] WA3W;
  logic [CNT_W-1:0]  stall_cnt, bubble_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ValidE      <= 1'b0;
      RA1E        <= '0;
      RA2E        <= '0;
      WA3E        <= '0;
      RegWriteE   <= 1'b0;
      MemToRegE_r <= 1'b0;
      ValidM      <= 1'b0;
      WA3M        <= '0;
      RegWriteM_r <= 1'b0;
      ValidW      <= 1'b0;
      WA3W        <= '0;
      RegWriteW_r <= 1'b0;
      stall_cnt   <= '0;
      bubble_cnt  <= '0;
    end else begin
      // FlushE outranks StallD; a stalled D is simply re-presented by the datapath.
      if (hz.FlushE) begin
        ValidE      <= 1'b0;
        RA1E        <= '0;
        RA2E        <= '0;
        WA3E        <= '0;
        RegWriteE   <= 1'b0;
        MemToRegE_r <= 1'b0;
      end else begin
        ValidE      <= hz.ValidD;
        RA1E        <= hz.RA1D;
        RA2E        <= hz.RA2D;
        WA3E        <= hz.WA3D;
        RegWriteE   <= hz.RegWriteD;
        MemToRegE_r <= hz.MemToRegD;
      end

      ValidM      <= ValidE;
      WA3M        <= WA3E;
      RegWriteM_r <= RegWriteE;
      ValidW      <= ValidM;
      WA3W        <= WA3M;
      RegWriteW_r <= RegWriteM_r;

      if (hz.StallD && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (hz.FlushE && hz.ValidD && bubble_cnt != CNT_MAX)
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

  // Every term is stage-valid gated, so stale or undriven addresses never raise a match.
  assign hz.Match_1E_M  = ValidE & ValidM & (RA1E == WA3M) & (RA1E != PC_IDX);
  assign hz.Match_1E_W  = ValidE & ValidW & (RA1E == WA3W) & (RA1E != PC_IDX);
  assign hz.Match_2E_M  = ValidE & ValidM & (RA2E == WA3M) & (RA2E != PC_IDX);
  assign hz.Match_2E_W  = ValidE & ValidW & (RA2E == WA3W) & (RA2E != PC_IDX);
  assign hz.Match_12D_E = hz.ValidD & ValidE &
                          (((hz.RA1D == WA3E) & (hz.RA1D != PC_IDX)) |
                           ((hz.RA2D == WA3E) & (hz.RA2D != PC_IDX)));

  assign hz.RegWriteM   = ValidM & RegWriteM_r;
  assign hz.RegWriteW   = ValidW & RegWriteW_r;
  assign hz.MemToRegE   = ValidE & MemToRegE_r;
  assign hz.StallCount  = stall_cnt;
  assign hz.BubbleCount = bubble_cnt;
endmodule

// File: tb/tb_hazard_match_tracker.sv
// Directed bench for hazard_match_tracker with hand-computed expectations; counters are narrowed to 4 bits to reach saturation.
module tb_hazard_match_tracker;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  hazard_match_tracker_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) hz ();

  hazard_match_tracker #(.ADDR_W(ADDR_W), .PC_REG(15), .CNT_W(CNT_W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_d(input logic v, input logic [3:0] ra1, input logic [3:0] ra2,
                         input logic [3:0] wa3, input logic rw, input logic m2r);
    hz.ValidD    = v;
    hz.RA1D      = ra1;
    hz.RA2D      = ra2;
    hz.WA3D      = wa3;
    hz.RegWriteD = rw;
    hz.MemToRegD = m2r;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {8'd0, hz.Match_1E_M, hz.Match_1E_W, hz.Match_2E_M, hz.Match_2E_W,
                           hz.Match_12D_E, hz.RegWriteM, hz.RegWriteW, hz.MemToRegE}, 16'd0);
    check({tag, "_stall"}, 16'(hz.StallCount), 16'd0);
    check({tag, "_bubble"}, 16'(hz.BubbleCount), 16'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    hz.StallD = 1'b0;
    hz.FlushE = 1'b0;
    drive_d(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

    // 1: reset then idle
    repeat (3) step();
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (5) step();
    check_all_zero("idle");

    // 2: back-to-back dependency on R3
    drive_d(1'b1, 4'd0, 4'd0, 4'd3, 1'b1, 1'b0);
    step();
    drive_d(1'b1, 4'd3, 4'd1, 4'd4, 1'b0, 1'b0);
    #1 check("b2b_12D_E", 16'(hz.Match_12D_E), 16'd1);
    step();
    check("b2b_1E_M", 16'(hz.Match_1E_M), 16'd1);
    check("b2b_RegWriteM", 16'(hz.RegWriteM), 16'd1);
    check("b2b_2E_M", 16'(hz.Match_2E_M), 16'd0);
    step();  // D re-presents the reader while the producer reaches W
    check("b2b_1E_W", 16'(hz.Match_1E_W), 16'd1);
    check("b2b_RegWriteW", 16'(hz.RegWriteW), 16'd1);
    check("b2b_1E_M_gone", 16'(hz.Match_1E_M), 16'd0);
    drive_d(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    repeat (3) step();

    // 3: load-use with simultaneous stall and flush
    drive_d(1'b1, 4'd0, 4'd0, 4'd5, 1'b1, 1'b1);
    step();
    drive_d(1'b1, 4'd7, 4'd5, 4'd6, 1'b1, 1'b0);
    #1 check("lu_12D_E", 16'(hz.Match_12D_E), 16'd1);
    check("lu_MemToRegE", 16'(hz.MemToRegE), 16'd1);
    hz.StallD = 1'b1;
    hz.FlushE = 1'b1;
    step();
    hz.StallD = 1'b0;
    hz.FlushE = 1'b0;
    #1 check("lu_MemToRegE_bubble", 16'(hz.MemToRegE), 16'd0);
    check("lu_12D_E_bubble", 16'(hz.Match_12D_E), 16'd0);
    check("lu_stall_cnt", 16'(hz.StallCount), 16'd1);
    check("lu_bubble_cnt", 16'(hz.BubbleCount), 16'd1);
    check("lu_RegWriteM", 16'(hz.RegWriteM), 16'd1);
    step();
    check("lu_2E_W", 16'(hz.Match_2E_W), 16'd1);
    check("lu_2E_M", 16'(hz.Match_2E_M), 16'd0);
    check("lu_1E_W", 16'(hz.Match_1E_W), 16'd0);
    drive_d(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    repeat (3) step();

    // 4: R15 is never matched
    drive_d(1'b1, 4'd0, 4'd0, 4'd15, 1'b1, 1'b0);
    step();
    drive_d(1'b1, 4'd15, 4'd15, 4'd2, 1'b0, 1'b0);
    #1 check("pc_12D_E", 16'(hz.Match_12D_E), 16'd0);
    step();
    check("pc_E_M", {14'd0, hz.Match_1E_M, hz.Match_2E_M}, 16'd0);
    check("pc_RegWriteM", 16'(hz.RegWriteM), 16'd1);
    step();
    check("pc_E_W", {14'd0, hz.Match_1E_W, hz.Match_2E_W}, 16'd0);
    check("pc_RegWriteW", 16'(hz.RegWriteW), 16'd1);
    drive_d(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    repeat (3) step();

    // 5: flushing an invalid D slot is not counted
    drive_d(1'b1, 4'd0, 4'd0, 4'd9, 1'b1, 1'b1);
    step();
    check("fi_MemToRegE_before", 16'(hz.MemToRegE), 16'd1);
    drive_d(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    hz.FlushE = 1'b1;
    step();
    hz.FlushE = 1'b0;
    check("fi_bubble_cnt", 16'(hz.BubbleCount), 16'd1);
    check("fi_MemToRegE_after", 16'(hz.MemToRegE), 16'd0);

    // 6: saturation of both counters, then async reset mid-cycle
    hz.StallD = 1'b1;
    hz.FlushE = 1'b1;
    drive_d(1'b1, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0);
    repeat (20) step();
    check("sat_stall_cnt", 16'(hz.StallCount), 16'd15);
    check("sat_bubble_cnt", 16'(hz.BubbleCount), 16'd15);
    hz.StallD = 1'b0;
    hz.FlushE = 1'b0;
    drive_d(1'b1, 4'd0, 4'd0, 4'd3, 1'b1, 1'b0);
    step();
    drive_d(1'b1, 4'd3, 4'd0, 4'd4, 1'b0, 1'b0);
    step();
    check("pre_rst_1E_M", 16'(hz.Match_1E_M), 16'd1);
    check("pre_rst_RegWriteM", 16'(hz.RegWriteM), 16'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    #1 rst_n = 1'b1;
    drive_d(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    step();
    check_all_zero("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_match_tracker.md
Name: hazard_match_tracker

Overview:
- Producer side of the hazard handshake. Carries register-address and write-control metadata down the E, M and W pipeline stages, and generates the Match_* comparisons and stage-control flags that the hazard unit consumes.
- Consumes the hazard unit's StallD/FlushE back, so it inserts bubbles and holds state consistently with the datapath pipeline registers.
- Also keeps saturating stall and bubble counters for performance debug.

Parameters:
- ADDR_W, 4, register-address width (16-entry register file).
- PC_REG, 15, register index that is never forwarded (PC reads are sourced by the datapath).
- CNT_W, 16, width of each performance counter.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- ValidD  input  1  decode stage holds a real instruction.
- RA1D  input  ADDR_W  decode source register 1.
- RA2D  input  ADDR_W  decode source register 2.
- WA3D  input  ADDR_W  decode destination register.
- RegWriteD  input  1  decode instruction writes the register file.
- MemToRegD  input  1  decode instruction is a load.
- StallD  input  1  from hazard unit; decode stage is held this cycle.
- FlushE  input  1  from hazard unit; execute stage loads a bubble.
- Match_1E_M  output  1  E src1 equals M destination.
- Match_1E_W  output  1  E src1 equals W destination.
- Match_2E_M  output  1  E src2 equals M destination.
- Match_2E_W  output  1  E src2 equals W destination.
- Match_12D_E  output  1  D src1 or D src2 equals E destination.
- RegWriteM  output  1  M stage writes the register file (valid-qualified).
- RegWriteW  output  1  W stage writes the register file (valid-qualified).
- MemToRegE  output  1  E stage is a load (valid-qualified).
- StallCount  output  CNT_W  cycles with StallD high, saturating.
- BubbleCount  output  CNT_W  bubbles inserted by FlushE, saturating.

Behaviour:
- State registers:
  - E: ValidE, RA1E, RA2E, WA3E, RegWriteE, MemToRegE_r.
  - M: ValidM, WA3M, RegWriteM_r.
  - W: ValidW, WA3W, RegWriteW_r.
- Reset (async, rst_n low): all state registers and both counters go to 0. All outputs therefore read 0 during and immediately after reset, because every Match and flag is gated by a stage-valid bit.
- Each rising edge, in priority order:
  - E update: FlushE=1 loads a bubble (all E fields 0, ValidE=0). Otherwise E captures the D inputs, with ValidE=ValidD. FlushE takes priority over StallD; StallD alone does not hold E, so E still captures D (the upstream datapath holds D).
  - M and W always advance: M captures E, W captures M. There is no stall or flush on M or W.
- Match outputs: combinational from registered state plus the D inputs, with zero added latency so the hazard unit can forward in the same cycle.
  - Match_1E_M = ValidE & ValidM & (RA1E==WA3M) & (RA1E!=PC_REG). The other E-source matches follow the same form with RA2E and/or the W stage.
  - Match_12D_E = ValidD & ValidE & (((RA1D==WA3E)&(RA1D!=PC_REG)) | ((RA2D==WA3E)&(RA2D!=PC_REG))).
- Flags:
  - RegWriteM = ValidM & RegWriteM_r.
  - RegWriteW = ValidW & RegWriteW_r.
  - MemToRegE = ValidE & MemToRegE_r.
- Counters:
  - StallCount increments on each edge where StallD=1.
  - BubbleCount increments on each edge where FlushE=1 and ValidD=1; an invalid instruction squashed by FlushE is not counted.
  - Both counters saturate at 2^CNT_W-1 and never wrap.
- Simultaneous StallD=1 and FlushE=1 (load-use): E receives a bubble, both counters increment, and the same D instruction is presented again next cycle.
- Reset asserted mid-operation clears all in-flight stages immediately, with no pending forwards or stalls. No X propagates from the D inputs when ValidD=0: every Match derived from them is gated off.

Test Plan:
1. Reset then idle: rst_n low for 3 cycles, then ValidD=0 for 5 cycles -> all Match outputs, RegWriteM/W, MemToRegE and both counters stay 0.
2. Back-to-back dependency: I0 writes R3 (RegWriteD=1), then I1 reads RA1D=3 -> with I1 in E, Match_1E_M=1 and RegWriteM=1. One cycle later Match_1E_W=1 and RegWriteW=1.
3. Load-use: load with WA3D=5 enters E; D holds RA2D=5 -> Match_12D_E=1 and MemToRegE=1. Drive StallD=FlushE=1 for one edge -> ValidE=0, MemToRegE=0, StallCount=1, BubbleCount=1; the re-presented instruction then shows Match_2E_W=1 two cycles later.
4. PC exclusion: producer writes R15 and consumer reads R15 in both source slots -> every Match stays 0.
5. Flush of invalid slot: FlushE=1 with ValidD=0 -> BubbleCount is unchanged, E becomes a bubble.
6. Saturation and async reset: with CNT_W=4, hold StallD=1 for 20 cycles -> StallCount stops at 15. Pulse rst_n low between clock edges -> counters and all outputs go to 0 immediately.
